// File: rtl/rob_completion_tracker.sv
// rob_completion_tracker: reorder-buffer tracker that allocates entries, records completions and retires them in order, flushing on mispredict.
// Ports: i_clock/i_reset (async high); i_alloc_* dispatch in, o_alloc_ready/o_alloc_idx grants;
// i_upd_* per-lane completion updates; o_retire_* in-order retirement; o_flush/o_flush_target redirect; o_count occupancy.
module rob_completion_tracker #(
  parameter int N      = 2,
  parameter int ROB_SZ = 32,
  parameter int IDX_W  = $clog2(ROB_SZ),
  parameter int ADDR_W = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [N-1:0]          i_alloc_valid,
  output logic                  o_alloc_ready,
  output logic [N*IDX_W-1:0]    o_alloc_idx,
  input  logic [N-1:0]          i_upd_valid,
  input  logic [N*IDX_W-1:0]    i_upd_idx,
  input  logic [N-1:0]          i_upd_mispredict,
  input  logic [N-1:0]          i_upd_branch_taken,
  input  logic [N*ADDR_W-1:0]   i_upd_branch_target,
  output logic [N-1:0]          o_retire_valid,
  output logic [N*IDX_W-1:0]    o_retire_idx,
  output logic [N-1:0]          o_retire_branch_taken,
  output logic [N*ADDR_W-1:0]   o_retire_branch_target,
  output logic                  o_flush,
  output logic [ADDR_W-1:0]     o_flush_target,
  output logic [IDX_W:0]        o_count
);
  logic [ROB_SZ-1:0] r_valid, r_cmpl, r_misp, r_taken;
  logic [ADDR_W-1:0] r_tgt [ROB_SZ];
  logic [IDX_W-1:0]  r_head, r_tail, w_h;
  logic [IDX_W:0]    r_count, w_k, w_r;
  logic              w_go, w_accept;
  assign o_count  = r_count;
  assign w_accept = o_alloc_ready & ~o_flush;
  always_comb begin
    w_k = '0;
    o_alloc_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_k = w_k + (IDX_W+1)'(i_alloc_valid[i]);
      o_alloc_idx[i*IDX_W +: IDX_W] = r_tail + IDX_W'(i);
    end
    o_alloc_ready = ((IDX_W+1)'(ROB_SZ) - r_count) >= w_k;
  end
  // A lane retires only while every lower lane retired and none of them mispredicted.
  always_comb begin
    w_go = 1'b1;
    w_r = '0;
    w_h = '0;
    o_flush = 1'b0;
    o_flush_target = '0;
    o_retire_valid = '0;
    o_retire_idx = '0;
    o_retire_branch_taken = '0;
    o_retire_branch_target = '0;
    for (int i = 0; i < N; i++) begin
      w_h = r_head + IDX_W'(i);
      o_retire_idx[i*IDX_W +: IDX_W] = w_h;
      o_retire_branch_taken[i] = r_taken[w_h];
      o_retire_branch_target[i*ADDR_W +: ADDR_W] = r_tgt[w_h];
      if (w_go && r_valid[w_h] && r_cmpl[w_h] && ((IDX_W+1)'(i) < r_count)) begin
        o_retire_valid[i] = 1'b1;
        w_r = w_r + 1'b1;
        if (r_misp[w_h]) begin
          o_flush = 1'b1;
          o_flush_target = r_tgt[w_h];
          w_go = 1'b0;
        end
      end else begin
        w_go = 1'b0;
      end
    end
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= '0;
      r_cmpl  <= '0;
      r_misp  <= '0;
      r_taken <= '0;
      for (int e = 0; e < ROB_SZ; e++) r_tgt[e] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (o_flush) begin
      r_valid <= '0;
      r_cmpl  <= '0;
      r_misp  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Ascending lane order lets the higher lane win a same-index collision.
      for (int i = 0; i < N; i++) begin
        if (i_upd_valid[i] && r_valid[i_upd_idx[i*IDX_W +: IDX_W]]) begin
          r_cmpl[i_upd_idx[i*IDX_W +: IDX_W]]  <= 1'b1;
          r_misp[i_upd_idx[i*IDX_W +: IDX_W]]  <= i_upd_mispredict[i];
          r_taken[i_upd_idx[i*IDX_W +: IDX_W]] <= i_upd_branch_taken[i];
          r_tgt[i_upd_idx[i*IDX_W +: IDX_W]]   <= i_upd_branch_target[i*ADDR_W +: ADDR_W];
        end
      end
      for (int i = 0; i < N; i++) begin
        if (o_retire_valid[i]) begin
          r_valid[r_head + IDX_W'(i)] <= 1'b0;
          r_cmpl[r_head + IDX_W'(i)]  <= 1'b0;
          r_misp[r_head + IDX_W'(i)]  <= 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (w_accept && i_alloc_valid[i]) begin
          r_valid[r_tail + IDX_W'(i)] <= 1'b1;
          r_cmpl[r_tail + IDX_W'(i)]  <= 1'b0;
          r_misp[r_tail + IDX_W'(i)]  <= 1'b0;
        end
      end
      r_head  <= r_head + w_r[IDX_W-1:0];
      r_tail  <= w_accept ? r_tail + w_k[IDX_W-1:0] : r_tail;
      r_count <= r_count + (w_accept ? w_k : '0) - w_r;
    end
  end
endmodule

// File: tb/tb_rob_completion_tracker.sv
// tb_rob_completion_tracker: directed self-checking bench for rob_completion_tracker (N=2, ROB_SZ=32).
module tb_rob_completion_tracker;
  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  alloc_valid, upd_valid, upd_misp, upd_taken;
  logic [9:0]  upd_idx;
  logic [63:0] upd_tgt;
  logic        alloc_ready, flush;
  logic [9:0]  alloc_idx, retire_idx;
  logic [1:0]  retire_valid, retire_taken;
  logic [63:0] retire_tgt;
  logic [31:0] flush_target;
  logic [5:0]  count;
  int pass = 0, total = 0;

  rob_completion_tracker #(.N(2), .ROB_SZ(32), .ADDR_W(32)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_alloc_valid(alloc_valid), .o_alloc_ready(alloc_ready), .o_alloc_idx(alloc_idx),
    .i_upd_valid(upd_valid), .i_upd_idx(upd_idx), .i_upd_mispredict(upd_misp),
    .i_upd_branch_taken(upd_taken), .i_upd_branch_target(upd_tgt),
    .o_retire_valid(retire_valid), .o_retire_idx(retire_idx),
    .o_retire_branch_taken(retire_taken), .o_retire_branch_target(retire_tgt),
    .o_flush(flush), .o_flush_target(flush_target), .o_count(count));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst) assert ((alloc_valid & (alloc_valid + 2'd1)) == 2'd0) else $error("non-contiguous alloc_valid %b", alloc_valid);

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    alloc_valid = '0; upd_valid = '0; upd_idx = '0; upd_misp = '0; upd_taken = '0; upd_tgt = '0;
  endtask

  task automatic upd(input int l, input logic [4:0] idx, input logic m, input logic t, input logic [31:0] tg);
    upd_valid[l] = 1'b1; upd_idx[l*5 +: 5] = idx; upd_misp[l] = m; upd_taken[l] = t; upd_tgt[l*32 +: 32] = tg;
  endtask

  task automatic do_reset;
    idle(); rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic test_reset;
    idle(); rst = 1'b1; alloc_valid = 2'b11; #1;
    total++; if (retire_valid !== 2'b00) $display("FAIL reset_retire_valid got %b exp 00", retire_valid); else pass++;
    total++; if (flush !== 1'b0) $display("FAIL reset_flush got %b exp 0", flush); else pass++;
    total++; if (flush_target !== 32'h0) $display("FAIL reset_flush_target got %h exp 0", flush_target); else pass++;
    total++; if (count !== 6'd0) $display("FAIL reset_count got %0d exp 0", count); else pass++;
    total++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready got %b exp 1", alloc_ready); else pass++;
    total++; if (alloc_idx !== 10'h020) $display("FAIL reset_alloc_idx got %h exp 020", alloc_idx); else pass++;
    step(); rst = 1'b0; idle();
  endtask

  task automatic test_fill;
    logic [9:0] e;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      alloc_valid = 2'b11; #1;
      e = {5'(2*c+1), 5'(2*c)};
      total++; if (alloc_idx !== e) $display("FAIL fill_alloc_idx c=%0d got %h exp %h", c, alloc_idx, e); else pass++;
      total++; if (alloc_ready !== 1'b1) $display("FAIL fill_ready c=%0d got %b exp 1", c, alloc_ready); else pass++;
      step();
    end
    alloc_valid = 2'b01; #1;
    total++; if (count !== 6'd32) $display("FAIL fill_count got %0d exp 32", count); else pass++;
    total++; if (alloc_ready !== 1'b0) $display("FAIL fill_full_ready got %b exp 0", alloc_ready); else pass++;
    total++; if (retire_valid !== 2'b00) $display("FAIL fill_no_retire got %b exp 00", retire_valid); else pass++;
    step(); idle(); #1;
    total++; if (count !== 6'd32) $display("FAIL fill_reject_count got %0d exp 32", count); else pass++;
  endtask

  task automatic test_in_order;
    do_reset();
    alloc_valid = 2'b11; step(); step(); idle();
    upd(0, 5'd1, 1'b0, 1'b1, 32'h11); step(); idle(); #1;
    total++; if (retire_valid !== 2'b00) $display("FAIL order_blocked got %b exp 00", retire_valid); else pass++;
    total++; if (count !== 6'd4) $display("FAIL order_count4 got %0d exp 4", count); else pass++;
    upd(0, 5'd0, 1'b0, 1'b0, 32'h22); step(); idle(); #1;
    total++; if (retire_valid !== 2'b11) $display("FAIL order_retire got %b exp 11", retire_valid); else pass++;
    total++; if (retire_idx !== 10'h020) $display("FAIL order_retire_idx got %h exp 020", retire_idx); else pass++;
    total++; if (retire_tgt[63:32] !== 32'h11) $display("FAIL order_lane1_target got %h exp 11", retire_tgt[63:32]); else pass++;
    total++; if (retire_taken !== 2'b10) $display("FAIL order_taken got %b exp 10", retire_taken); else pass++;
    total++; if (flush !== 1'b0) $display("FAIL order_flush got %b exp 0", flush); else pass++;
    step(); #1;
    total++; if (count !== 6'd2) $display("FAIL order_count2 got %0d exp 2", count); else pass++;
    total++; if (retire_idx[4:0] !== 5'd2) $display("FAIL order_head got %0d exp 2", retire_idx[4:0]); else pass++;
    total++; if (retire_valid !== 2'b00) $display("FAIL order_after got %b exp 00", retire_valid); else pass++;
  endtask

  task automatic test_flush;
    do_reset();
    alloc_valid = 2'b11; step(); idle();
    upd(0, 5'd0, 1'b1, 1'b1, 32'h0000_1040); upd(1, 5'd1, 1'b0, 1'b0, 32'h2000); step(); idle();
    alloc_valid = 2'b11; #1;
    total++; if (retire_valid !== 2'b01) $display("FAIL flush_retire got %b exp 01", retire_valid); else pass++;
    total++; if (flush !== 1'b1) $display("FAIL flush_flag got %b exp 1", flush); else pass++;
    total++; if (flush_target !== 32'h0000_1040) $display("FAIL flush_target got %h exp 00001040", flush_target); else pass++;
    step(); idle(); #1;
    total++; if (count !== 6'd0) $display("FAIL flush_count got %0d exp 0", count); else pass++;
    total++; if (alloc_idx[4:0] !== 5'd0) $display("FAIL flush_tail got %0d exp 0", alloc_idx[4:0]); else pass++;
    total++; if (retire_idx[4:0] !== 5'd0) $display("FAIL flush_head got %0d exp 0", retire_idx[4:0]); else pass++;
    total++; if (flush !== 1'b0) $display("FAIL flush_clear got %b exp 0", flush); else pass++;
    total++; if (flush_target !== 32'h0) $display("FAIL flush_target_clear got %h exp 0", flush_target); else pass++;
  endtask

  task automatic test_wrap;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      idle();
      if (c < 15) alloc_valid = 2'b11;
      if (c > 0) begin upd(0, 5'(2*c-2), 1'b0, 1'b0, 32'h0); upd(1, 5'(2*c-1), 1'b0, 1'b0, 32'h0); end
      step();
    end
    idle(); step(); #1;
    total++; if (count !== 6'd0) $display("FAIL wrap_drain got %0d exp 0", count); else pass++;
    total++; if (alloc_idx[4:0] !== 5'd30) $display("FAIL wrap_tail got %0d exp 30", alloc_idx[4:0]); else pass++;
    total++; if (retire_idx[4:0] !== 5'd30) $display("FAIL wrap_head got %0d exp 30", retire_idx[4:0]); else pass++;
    alloc_valid = 2'b11; #1;
    total++; if (alloc_idx !== 10'h3FE) $display("FAIL wrap_alloc_a got %h exp 3fe", alloc_idx); else pass++;
    step(); #1;
    total++; if (alloc_idx !== 10'h020) $display("FAIL wrap_alloc_b got %h exp 020", alloc_idx); else pass++;
    step(); idle(); #1;
    total++; if (count !== 6'd4) $display("FAIL wrap_count4 got %0d exp 4", count); else pass++;
    upd(0, 5'd30, 1'b0, 1'b0, 32'h0); upd(1, 5'd31, 1'b0, 1'b0, 32'h0); step(); idle();
    upd(0, 5'd0, 1'b0, 1'b0, 32'h0); upd(1, 5'd1, 1'b0, 1'b0, 32'h0); #1;
    total++; if (retire_valid !== 2'b11) $display("FAIL wrap_retire_a got %b exp 11", retire_valid); else pass++;
    total++; if (retire_idx !== 10'h3FE) $display("FAIL wrap_retire_idx_a got %h exp 3fe", retire_idx); else pass++;
    step(); idle(); #1;
    total++; if (retire_valid !== 2'b11) $display("FAIL wrap_retire_b got %b exp 11", retire_valid); else pass++;
    total++; if (retire_idx !== 10'h020) $display("FAIL wrap_retire_idx_b got %h exp 020", retire_idx); else pass++;
    total++; if (count !== 6'd2) $display("FAIL wrap_count2 got %0d exp 2", count); else pass++;
    step(); #1;
    total++; if (count !== 6'd0) $display("FAIL wrap_count0 got %0d exp 0", count); else pass++;
  endtask

  task automatic test_same_idx;
    do_reset();
    alloc_valid = 2'b11; step(); step(); step(); idle();
    upd(0, 5'd0, 1'b0, 1'b0, 32'h0); upd(1, 5'd1, 1'b0, 1'b0, 32'h0); step(); idle();
    upd(0, 5'd2, 1'b0, 1'b0, 32'h0); upd(1, 5'd3, 1'b0, 1'b0, 32'h0); step(); idle();
    upd(0, 5'd4, 1'b0, 1'b0, 32'h0); step(); idle();
    upd(0, 5'd5, 1'b0, 1'b0, 32'hA0); upd(1, 5'd5, 1'b0, 1'b1, 32'hB0); #1;
    total++; if (retire_valid !== 2'b01) $display("FAIL same_retire4 got %b exp 01", retire_valid); else pass++;
    step(); idle(); #1;
    total++; if (retire_valid !== 2'b01) $display("FAIL same_retire5 got %b exp 01", retire_valid); else pass++;
    total++; if (retire_idx[4:0] !== 5'd5) $display("FAIL same_idx got %0d exp 5", retire_idx[4:0]); else pass++;
    total++; if (retire_tgt[31:0] !== 32'hB0) $display("FAIL same_target got %h exp b0", retire_tgt[31:0]); else pass++;
    total++; if (retire_taken[0] !== 1'b1) $display("FAIL same_taken got %b exp 1", retire_taken[0]); else pass++;
    total++; if (count !== 6'd1) $display("FAIL same_count got %0d exp 1", count); else pass++;
    step(); #1;
    total++; if (count !== 6'd0) $display("FAIL same_count0 got %0d exp 0", count); else pass++;
  endtask

  task automatic test_async_reset;
    do_reset();
    alloc_valid = 2'b11; step(); step(); step(); idle();
    alloc_valid = 2'b01; upd(0, 5'd0, 1'b1, 1'b1, 32'h55); step(); idle(); #1;
    total++; if (count !== 6'd7) $display("FAIL areset_pre_count got %0d exp 7", count); else pass++;
    total++; if (flush !== 1'b1) $display("FAIL areset_pre_flush got %b exp 1", flush); else pass++;
    #1; rst = 1'b1; #1;
    total++; if (flush !== 1'b0) $display("FAIL areset_flush got %b exp 0", flush); else pass++;
    total++; if (flush_target !== 32'h0) $display("FAIL areset_flush_target got %h exp 0", flush_target); else pass++;
    total++; if (count !== 6'd0) $display("FAIL areset_count got %0d exp 0", count); else pass++;
    total++; if (retire_valid !== 2'b00) $display("FAIL areset_retire got %b exp 00", retire_valid); else pass++;
    total++; if (alloc_ready !== 1'b1) $display("FAIL areset_ready got %b exp 1", alloc_ready); else pass++;
    total++; if (alloc_idx !== 10'h020) $display("FAIL areset_alloc_idx got %h exp 020", alloc_idx); else pass++;
    step(); rst = 1'b0;
  endtask

  initial begin
    idle();
    step();
    test_reset();
    test_fill();
    test_in_order();
    test_flush();
    test_wrap();
    test_same_idx();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
